// File: rtl/dt_threshold_packer.sv
// dt_threshold_packer: streams the 8-bit distance map out of the result RAM
// one pixel per clock, thresholds each pixel (res_di > thr) and packs the
// bits into 16-bit MSB-first words (bit 15 = leftmost pixel) on the pk_* port.
// Optional feature macro: DTP_POPCOUNT_EN adds the fg_cnt foreground counter.
//
// state | meaning
// IDLE  | waiting for start; done holds the result of the previous run
// RUN   | issuing one pixel read per cycle, p = res_addr
// FLUSH | reads finished; draining the capture pipeline until the last word
//       | is written, then done is set and the FSM returns straight to IDLE
//       | (the DONE step is folded into that FLUSH -> IDLE transition)
`timescale 1ns/1ps

module dt_threshold_packer #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_AW = 14,
  parameter int WRD_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        thr,
  output logic              res_rd,
  output logic [PIX_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              pk_wr,
  output logic [WRD_AW-1:0] pk_addr,
  output logic [15:0]       pk_do,
  output logic              done
`ifdef DTP_POPCOUNT_EN
  ,
  output logic [14:0]       fg_cnt
`endif
);

  localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(IMG_W * IMG_H - 1);
  localparam logic [WRD_AW-1:0] LAST_WRD = WRD_AW'(IMG_W * IMG_H / 16 - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state;
  logic [7:0]        thr_q;
  logic              cap_vld;
  logic [PIX_AW-1:0] cap_addr;
  logic [14:0]       sr;
  logic              pix_bit;
  logic              start_acc;

  assign start_acc = (state == IDLE) && start;
  assign pix_bit   = (res_di > thr_q);

  // Sequencer: accepts start, walks the pixel addresses, waits for the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      thr_q    <= 8'd0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            thr_q    <= thr;
            done     <= 1'b0;
            res_rd   <= 1'b1;
            res_addr <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (res_addr == LAST_PIX) begin
            res_rd <= 1'b0;
            state  <= FLUSH;
          end else begin
            res_addr <= res_addr + PIX_AW'(1);
          end
        end
        FLUSH: begin
          if (pk_wr && (pk_addr == LAST_WRD)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture/pack: one cycle behind the read, shift bits in and emit each full word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vld  <= 1'b0;
      cap_addr <= '0;
      sr       <= '0;
      pk_wr    <= 1'b0;
      pk_addr  <= '0;
      pk_do    <= '0;
`ifdef DTP_POPCOUNT_EN
      fg_cnt   <= '0;
`endif
    end else begin
      cap_vld  <= res_rd;
      cap_addr <= res_addr;
      pk_wr    <= 1'b0;
      if (start_acc) begin
        sr <= '0;
`ifdef DTP_POPCOUNT_EN
        fg_cnt <= '0;
`endif
      end else if (cap_vld) begin
        sr <= {sr[13:0], pix_bit};
        if (&cap_addr[3:0]) begin
          pk_wr   <= 1'b1;
          pk_addr <= cap_addr[PIX_AW-1:4];
          pk_do   <= {sr, pix_bit};
        end
`ifdef DTP_POPCOUNT_EN
        fg_cnt <= fg_cnt + 15'(pix_bit);
`endif
      end
    end
  end

endmodule

// File: tb/tb_dt_threshold_packer.sv
// Bench for dt_threshold_packer: a behavioural result-RAM model feeds the DUT,
// runs are captured cycle-by-cycle relative to the start edge, and each test
// compares the captured writes against words computed from the map contents.
`timescale 1ns/1ps

module tb_dt_threshold_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di = 8'd0;
  logic        pk_wr;
  logic [9:0]  pk_addr;
  logic [15:0] pk_do;
  logic        done;
`ifdef DTP_POPCOUNT_EN
  logic [14:0] fg_cnt;
`endif

  dt_threshold_packer dut (
    .clk(clk), .reset(reset), .start(start), .thr(thr),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .pk_wr(pk_wr), .pk_addr(pk_addr), .pk_do(pk_do), .done(done)
`ifdef DTP_POPCOUNT_EN
    , .fg_cnt(fg_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16384];

  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cyc  [1024];
  logic [9:0]  wr_addr [1024];
  logic [15:0] wr_data [1024];
  int          n_wr, done_cyc, rd_bad, wr_after_rst;
  logic [42:0] rst_vec;
  logic [13:0] end_addr;
  logic        end_rd;
  logic [14:0] end_fg, rst_fg;

  function automatic logic [15:0] exp_word(int w, logic [7:0] t);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[15-b] = (mem[16*w+b] > t);
    return r;
  endfunction

  function automatic int exp_fg(logic [7:0] t);
    int c = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] > t) c++;
    return c;
  endfunction

  // Starts a run at the current negedge and records what the DUT does.
  task automatic do_run(input logic [7:0] t, input int pulse_cyc, input logic [7:0] pulse_thr,
                        input int abort_cyc);
    n_wr = 0; done_cyc = 0; rd_bad = 0; wr_after_rst = 0;
    rst_vec = '1; rst_fg = '1; end_addr = '0; end_rd = 1'b1; end_fg = '1;
    thr = t; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 16500; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; thr = ~t; end
      if (n == pulse_cyc) begin start = 1'b1; thr = pulse_thr; end
      else if (pulse_cyc != 0 && n == pulse_cyc + 1) start = 1'b0;
      if (n <= 16384) begin
        if (res_rd !== 1'b1 || res_addr !== 14'(n-1)) rd_bad++;
      end else if (res_rd !== 1'b0) rd_bad++;
      if (pk_wr === 1'b1 && n_wr < 1024) begin
        wr_cyc[n_wr] = n; wr_addr[n_wr] = pk_addr; wr_data[n_wr] = pk_do; n_wr++;
      end
      if (done === 1'b1) begin
        done_cyc = n; end_addr = res_addr; end_rd = res_rd;
`ifdef DTP_POPCOUNT_EN
        end_fg = fg_cnt;
`endif
        break;
      end
      if (abort_cyc != 0 && n == abort_cyc) begin
        reset = 1'b1;
        #1;
        rst_vec = {res_rd, res_addr, pk_wr, pk_addr, pk_do, done};
`ifdef DTP_POPCOUNT_EN
        rst_fg = fg_cnt;
`else
        rst_fg = '0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) begin
          @(negedge clk);
          if (pk_wr !== 1'b0) wr_after_rst++;
        end
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; thr = 8'd0;
    #3;
    n_cmp++; if (res_rd !== 1'b0) begin n_bad++; $display("FAIL reset res_rd: got %b want 0", res_rd); end
    n_cmp++; if (res_addr !== 14'd0) begin n_bad++; $display("FAIL reset res_addr: got %0d want 0", res_addr); end
    n_cmp++; if (pk_wr !== 1'b0) begin n_bad++; $display("FAIL reset pk_wr: got %b want 0", pk_wr); end
    n_cmp++; if (pk_addr !== 10'd0) begin n_bad++; $display("FAIL reset pk_addr: got %0d want 0", pk_addr); end
    n_cmp++; if (pk_do !== 16'h0) begin n_bad++; $display("FAIL reset pk_do: got %h want 0000", pk_do); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
`ifdef DTP_POPCOUNT_EN
    n_cmp++; if (fg_cnt !== 15'd0) begin n_bad++; $display("FAIL reset fg_cnt: got %0d want 0", fg_cnt); end
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    foreach (mem[i]) mem[i] = 8'd0;
    do_run(8'd0, 0, 8'd0, 0);
    n_cmp++; if (n_wr !== 1024) begin n_bad++; $display("FAIL all_zero writes: got %0d want 1024", n_wr); end
    for (int w = 0; w < n_wr; w++) begin
      n_cmp++;
      if (wr_cyc[w] !== 16*w+18 || wr_addr[w] !== 10'(w) || wr_data[w] !== 16'h0000) begin
        n_bad++; $display("FAIL all_zero word %0d: got cyc %0d addr %0d data %h want cyc %0d addr %0d data 0000",
                          w, wr_cyc[w], wr_addr[w], wr_data[w], 16*w+18, w);
      end
    end
    n_cmp++; if (done_cyc !== 16387) begin n_bad++; $display("FAIL all_zero done cycle: got %0d want 16387", done_cyc); end
    n_cmp++; if (rd_bad !== 0) begin n_bad++; $display("FAIL all_zero read sequence: got %0d bad cycles want 0", rd_bad); end
    n_cmp++; if (end_addr !== 14'd16383 || end_rd !== 1'b0) begin n_bad++; $display("FAIL all_zero end state: got addr %0d rd %b want 16383 0", end_addr, end_rd); end
`ifdef DTP_POPCOUNT_EN
    n_cmp++; if (end_fg !== 15'd0) begin n_bad++; $display("FAIL all_zero fg_cnt: got %0d want 0", end_fg); end
`endif
  endtask

  task automatic test_reset_midrun();
    foreach (mem[i]) mem[i] = 8'd0;
    mem[0] = 8'd5;
    do_run(8'd4, 0, 8'd0, 100);
    n_cmp++; if (n_wr !== 6) begin n_bad++; $display("FAIL midrun writes before reset: got %0d want 6", n_wr); end
    n_cmp++; if (n_wr > 0 && wr_data[0] !== 16'h8000) begin n_bad++; $display("FAIL midrun word0: got %h want 8000", wr_data[0]); end
    n_cmp++; if (rst_vec !== 43'd0 || rst_fg !== 15'd0) begin n_bad++; $display("FAIL midrun outputs at reset: got %h fg %0d want 0", rst_vec, rst_fg); end
    n_cmp++; if (wr_after_rst !== 0) begin n_bad++; $display("FAIL midrun pk_wr after reset: got %0d want 0", wr_after_rst); end
    do_run(8'd4, 0, 8'd0, 0);
    n_cmp++; if (n_wr !== 1024) begin n_bad++; $display("FAIL restart writes: got %0d want 1024", n_wr); end
    for (int w = 0; w < n_wr; w++) begin
      n_cmp++;
      if (wr_cyc[w] !== 16*w+18 || wr_addr[w] !== 10'(w) || wr_data[w] !== ((w == 0) ? 16'h8000 : 16'h0000)) begin
        n_bad++; $display("FAIL restart word %0d: got cyc %0d addr %0d data %h want cyc %0d data %h",
                          w, wr_cyc[w], wr_addr[w], wr_data[w], 16*w+18, (w == 0) ? 16'h8000 : 16'h0000);
      end
    end
    n_cmp++; if (done_cyc !== 16387) begin n_bad++; $display("FAIL restart done cycle: got %0d want 16387", done_cyc); end
`ifdef DTP_POPCOUNT_EN
    n_cmp++; if (end_fg !== 15'd1) begin n_bad++; $display("FAIL restart fg_cnt: got %0d want 1", end_fg); end
`endif
  endtask

  task automatic test_strict();
    foreach (mem[i]) mem[i] = 8'd0;
    mem[0] = 8'd5;
    do_run(8'd5, 0, 8'd0, 40);
    n_cmp++; if (n_wr !== 2) begin n_bad++; $display("FAIL strict writes: got %0d want 2", n_wr); end
    n_cmp++; if (n_wr > 0 && (wr_data[0] !== 16'h0000 || wr_cyc[0] !== 18 || wr_addr[0] !== 10'd0)) begin
      n_bad++; $display("FAIL strict word0: got data %h cyc %0d addr %0d want 0000 18 0", wr_data[0], wr_cyc[0], wr_addr[0]);
    end
    n_cmp++; if (wr_after_rst !== 0) begin n_bad++; $display("FAIL strict pk_wr after reset: got %0d want 0", wr_after_rst); end
  endtask

  task automatic test_odd_map();
    foreach (mem[i]) mem[i] = 8'(i % 2);
    do_run(8'd0, 0, 8'd0, 0);
    n_cmp++; if (n_wr !== 1024) begin n_bad++; $display("FAIL odd writes: got %0d want 1024", n_wr); end
    for (int w = 0; w < n_wr; w++) begin
      n_cmp++;
      if (wr_cyc[w] !== 16*w+18 || wr_addr[w] !== 10'(w) || wr_data[w] !== 16'h5555) begin
        n_bad++; $display("FAIL odd word %0d: got cyc %0d addr %0d data %h want data 5555", w, wr_cyc[w], wr_addr[w], wr_data[w]);
      end
    end
    n_cmp++; if (done_cyc !== 16387) begin n_bad++; $display("FAIL odd done cycle: got %0d want 16387", done_cyc); end
`ifdef DTP_POPCOUNT_EN
    n_cmp++; if (end_fg !== 15'd8192) begin n_bad++; $display("FAIL odd fg_cnt: got %0d want 8192", end_fg); end
`endif
  endtask

  task automatic test_saturate();
    foreach (mem[i]) mem[i] = 8'hFF;
    do_run(8'hFE, 0, 8'd0, 0);
    n_cmp++; if (n_wr !== 1024) begin n_bad++; $display("FAIL sat writes: got %0d want 1024", n_wr); end
    for (int w = 0; w < n_wr; w++) begin
      n_cmp++;
      if (wr_cyc[w] !== 16*w+18 || wr_addr[w] !== 10'(w) || wr_data[w] !== 16'hFFFF) begin
        n_bad++; $display("FAIL sat word %0d: got cyc %0d addr %0d data %h want data ffff", w, wr_cyc[w], wr_addr[w], wr_data[w]);
      end
    end
    n_cmp++; if (done_cyc !== 16387) begin n_bad++; $display("FAIL sat done cycle: got %0d want 16387", done_cyc); end
`ifdef DTP_POPCOUNT_EN
    n_cmp++; if (end_fg !== 15'd16384) begin n_bad++; $display("FAIL sat fg_cnt: got %0d want 16384", end_fg); end
`endif
    do_run(8'hFF, 0, 8'd0, 60);
    n_cmp++; if (n_wr !== 3) begin n_bad++; $display("FAIL sat255 writes: got %0d want 3", n_wr); end
    for (int w = 0; w < n_wr; w++) begin
      n_cmp++;
      if (wr_data[w] !== 16'h0000) begin n_bad++; $display("FAIL sat255 word %0d: got %h want 0000", w, wr_data[w]); end
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] t;
    foreach (mem[i]) mem[i] = 8'($urandom);
    t = 8'($urandom_range(1, 254));
    do_run(t, 500, t ^ 8'h80, 0);
    n_cmp++; if (n_wr !== 1024) begin n_bad++; $display("FAIL ignore writes: got %0d want 1024", n_wr); end
    for (int w = 0; w < n_wr; w++) begin
      n_cmp++;
      if (wr_cyc[w] !== 16*w+18 || wr_addr[w] !== 10'(w) || wr_data[w] !== exp_word(w, t)) begin
        n_bad++; $display("FAIL ignore word %0d: got cyc %0d addr %0d data %h want cyc %0d data %h",
                          w, wr_cyc[w], wr_addr[w], wr_data[w], 16*w+18, exp_word(w, t));
      end
    end
    n_cmp++; if (done_cyc !== 16387) begin n_bad++; $display("FAIL ignore done cycle: got %0d want 16387", done_cyc); end
    n_cmp++; if (rd_bad !== 0) begin n_bad++; $display("FAIL ignore read sequence: got %0d bad cycles want 0", rd_bad); end
`ifdef DTP_POPCOUNT_EN
    n_cmp++; if (end_fg !== 15'(exp_fg(t))) begin n_bad++; $display("FAIL ignore fg_cnt: got %0d want %0d", end_fg, exp_fg(t)); end
`endif
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_reset_midrun();
    test_strict();
    test_odd_map();
    test_saturate();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dt_threshold_packer.md
# dt_threshold_packer

- Reads the 128x128 8-bit distance map from the result RAM (`res_*` port, read side), one pixel per cycle.
- Thresholds each pixel and packs 16 results per word into the same 1024x16 MSB-first word format as the binary input image.
- Output goes to a word-write port (`pk_*`), giving the inverse path from distance map back to packed binary (threshold erosion).
- Sits downstream of the distance-transform engine and is started after that engine's `done`.

## Interface
Parameters:
- `IMG_W`, 128, pixels per row; must be a multiple of 16.
- `IMG_H`, 128, rows.
- `PIX_AW`, 14, pixel address width (`log2(IMG_W*IMG_H)`).
- `WRD_AW`, 10, packed word address width (`PIX_AW-4`).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE.
- `start`  in  1  run request, sampled in IDLE only.
- `thr`  in  8  unsigned threshold, latched on accepted `start`.
- `res_rd`  out  1  result-RAM read enable.
- `res_addr`  out  PIX_AW  pixel address.
- `res_di`  in  8  read data, valid the cycle after `res_rd`/`res_addr`.
- `pk_wr`  out  1  packed-word write strobe, one cycle per word.
- `pk_addr`  out  WRD_AW  packed word address.
- `pk_do`  out  16  packed word; bit 15 is the leftmost pixel.
- `done`  out  1  run complete; held until the next accepted `start`.
- `fg_cnt`  out  15  foreground pixel count; present only with `DTP_POPCOUNT_EN`.

## Operation
- Reset values: `res_rd`=0, `res_addr`=0, `pk_wr`=0, `pk_addr`=0, `pk_do`=0, `done`=0, `fg_cnt`=0; state IDLE.
- All outputs are registered.
- States:
  - IDLE: on `start`=1, latch `thr`, clear `done`, clear `fg_cnt`, clear the pixel counter `p` and the shift register `sr`, go to RUN.
  - RUN: drive `res_rd`=1 and `res_addr`=`p`; increment `p` every cycle. When `p` = `IMG_W*IMG_H-1` has been issued, go to FLUSH.
  - FLUSH: `res_rd`=0. Wait for the last datum to be captured and the last word to be written, then go to DONE.
  - DONE: set `done`=1 and return to IDLE in the same transition.
- Capture: in the cycle after address `a` is issued, bit = (`res_di` > `thr`), unsigned and strict. Shift the bit into `sr` from the LSB side so that pixel `a` lands in bit 15-(`a` mod 16).
- Word write: when `a` mod 16 = 15 is captured, the next cycle has `pk_wr`=1, `pk_addr`=`a`>>4, `pk_do`=completed word. `pk_wr` deasserts the following cycle; `pk_addr`/`pk_do` hold their values.
- Reads and writes overlap. The pixel stream never stalls; throughput is 1 pixel/clock.
- `start` outside IDLE is ignored. `thr` changes after latching have no effect.
- `thr`=0 yields an object mask (every nonzero pixel becomes 1). `thr`=255 yields all zeros.
- Reset mid-run: everything returns to reset values immediately. The partial word is discarded and no further `pk_wr` is issued. A new `start` then begins a full run from pixel 0.

## Timing
- `start` sampled high at edge E0. Cycle n ≥ 1 after E0 has `res_rd`=1, `res_addr`=n-1, for n = 1..16384.
- Word `w` is written (`pk_wr`=1) in cycle 16w+18. The first write is in cycle 18; the last (w=1023) is in cycle 16386.
- `done` rises in cycle 16387 (the cycle after the last write). The block is back in IDLE in that cycle.
- A new `start` is accepted at the end of cycle 16387 or later. Back-to-back runs add no extra gap.
- `res_addr` holds 16383 after the run; `res_rd`=0 from cycle 16385.

## Configuration
- `DTP_POPCOUNT_EN` defined:
  - Adds `fg_cnt[14:0]`, cleared on accepted `start`.
  - Incremented by 1 for every captured pixel with bit=1.
  - Final value is stable when `done`=1; maximum 16384.
- Not defined: port `fg_cnt` and its counter are absent. All other behaviour is identical.

## Test plan
- All-zero map, `thr`=0 -> 1024 writes of 0x0000 at addresses 0..1023 in cycles 18..16386, one per 16 cycles. `done`=1 in cycle 16387; `fg_cnt`=0.
- Pixel 0 = 5, all others 0:
  - `thr`=4 -> word 0 = 0x8000 and all other words 0x0000.
  - `thr`=5 -> word 0 = 0x0000 (strict compare).
- Map value = `a`[0] (odd pixels 1), `thr`=0 -> every word 0x5555; `fg_cnt`=8192.
- All pixels 0xFF, `thr`=0xFE -> every word 0xFFFF; `fg_cnt`=16384. Same map with `thr`=0xFF -> every word 0x0000.
- `start` pulsed again in cycle 500 with `thr` changed -> ignored; results match the original `thr` and `done` timing is unchanged.
- `reset` asserted in cycle 100 -> all outputs 0 at once, no `pk_wr` afterwards. Restart with `start` -> full correct run, first write in cycle 18 relative to the new E0.
